// File: rtl/car_motion_controller.sv
// Car motion controller: moves the car floor by floor to a latched destination, then cycles the door.
// Latency: door opens |dest-floor|*TRAVEL_TICKS+1 cycles after the request cycle; busy for that + DOOR_TICKS + 1.
// Backpressure: req_ready only in IDLE; req_valid seen while busy is dropped, so the requester must hold or re-issue.
module car_motion_controller #(
  parameter logic [1:0] ST_FLOOR     = 2'b00,
  parameter logic [1:0] ND_FLOOR     = 2'b01,
  parameter logic [1:0] RD_FLOOR     = 2'b10,
  parameter int         TRAVEL_TICKS = 4,
  parameter int         DOOR_TICKS   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] open_when,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [1:0] floor,
  output logic       is_mooving,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       st_clr,
  output logic       nd_clr,
  output logic       rd_clr
);

  localparam int MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
  localparam int CNT_W     = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
  localparam logic [CNT_W-1:0] DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
    DOOR      = 3'd3,
    CLOSE     = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [1:0]       floor_nxt;
  logic [1:0]       dest, dest_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       clr, clr_nxt;   // {rd, nd, st}

  // Map a floor encoding onto its call-LED clear bit.
  function automatic logic [2:0] clr_of(input logic [1:0] f);
    logic [2:0] r;
    r = 3'b000;
    if (f == ST_FLOOR) r = 3'b001;
    if (f == ND_FLOOR) r = 3'b010;
    if (f == RD_FLOOR) r = 3'b100;
    return r;
  endfunction

  // Next-state logic: request acceptance, floor stepping, door timing.
  always_comb begin
    state_nxt = state;
    floor_nxt = floor;
    dest_nxt  = dest;
    cnt_nxt   = cnt;
    clr_nxt   = 3'b000;
    case (state)
      IDLE: begin
        // 2'b11 names no floor, so it is never accepted
        if (req_valid && open_when != 2'b11) begin
          dest_nxt = open_when;
          cnt_nxt  = '0;
          if (open_when > floor) begin
            state_nxt = MOVE_UP;
          end else if (open_when < floor) begin
            state_nxt = MOVE_DOWN;
          end else begin
            state_nxt = DOOR;
            clr_nxt   = clr_of(floor);
          end
        end
      end
      MOVE_UP, MOVE_DOWN: begin
        if (cnt == TRAVEL_LAST) begin
          cnt_nxt   = '0;
          floor_nxt = (state == MOVE_UP) ? floor + 2'd1 : floor - 2'd1;
          // Intermediate floors are passed without stopping
          if (floor_nxt == dest) begin
            state_nxt = DOOR;
            clr_nxt   = clr_of(floor_nxt);
          end
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DOOR: begin
        if (cnt == DOOR_LAST) begin
          cnt_nxt   = '0;
          state_nxt = CLOSE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CLOSE: begin
        // One closed-door busy cycle gives the queue a clean is_mooving fall
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, position, counter and clear-pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      floor <= ST_FLOOR;
      dest  <= ST_FLOOR;
      cnt   <= '0;
      clr   <= 3'b000;
    end else begin
      state <= state_nxt;
      floor <= floor_nxt;
      dest  <= dest_nxt;
      cnt   <= cnt_nxt;
      clr   <= clr_nxt;
    end
  end

  // Status flags decode straight from registered state only.
  assign req_ready  = (state == IDLE);
  assign is_mooving = (state != IDLE);
  assign motor_up   = (state == MOVE_UP);
  assign motor_down = (state == MOVE_DOWN);
  assign door_open  = (state == DOOR);
  assign st_clr     = clr[0];
  assign nd_clr     = clr[1];
  assign rd_clr     = clr[2];

endmodule

// File: tb/tb_car_motion_controller.sv
// Bench for car_motion_controller: directed scenarios plus random requests.
// Outputs are compared every cycle against a timeline model computed from elapsed time since accept.
// Inputs change and outputs are sampled on the falling edge.
module tb_car_motion_controller;

  localparam int TRAVEL = 4;
  localparam int DOORT  = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] open_when;
  logic       req_valid;
  logic       req_ready, is_mooving, motor_up, motor_down, door_open;
  logic       st_clr, nd_clr, rd_clr;
  logic [1:0] floor;

  car_motion_controller #(
    .ST_FLOOR(2'b00), .ND_FLOOR(2'b01), .RD_FLOOR(2'b10),
    .TRAVEL_TICKS(TRAVEL), .DOOR_TICKS(DOORT)
  ) dut (
    .clk(clk), .rst(rst), .open_when(open_when), .req_valid(req_valid),
    .req_ready(req_ready), .floor(floor), .is_mooving(is_mooving),
    .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
    .st_clr(st_clr), .nd_clr(nd_clr), .rd_clr(rd_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // {req_ready, floor, is_mooving, motor_up, motor_down, door_open, rd_clr, nd_clr, st_clr}
  logic [9:0] dut_vec;
  assign dut_vec = {req_ready, floor, is_mooving, motor_up, motor_down, door_open,
                    rd_clr, nd_clr, st_clr};
  localparam logic [9:0] RESET_VEC = 10'h200;

  // Reference model: a trip is described by start floor, destination and elapsed cycles.
  bit m_busy = 0;
  int m_t = 0, m_f = 0, m_d = 0, m_n = 0, m_dir = 0, m_cur = 0;
  int acc_cnt = 0, clr_cnt = 0;
  bit cnt_en = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0;
      m_cur  = 0;
      m_t    = 0;
    end else if (m_busy) begin
      m_t++;
      if (m_t == m_n * TRAVEL + DOORT + 1) begin
        m_busy = 0;
        m_cur  = m_d;
      end
    end else if (req_valid && open_when != 2'b11) begin
      m_busy = 1;
      m_f    = m_cur;
      m_d    = int'(open_when);
      m_dir  = (m_d > m_f) ? 1 : (m_d < m_f) ? -1 : 0;
      m_n    = (m_d > m_f) ? m_d - m_f : m_f - m_d;
      m_t    = 0;
      if (cnt_en) acc_cnt++;
    end
  end

  function automatic logic [9:0] exp_vec();
    int fl, arrive;
    logic mu, md, dr;
    logic [2:0] c;
    if (!m_busy) return {1'b1, 2'(m_cur), 7'b0};
    arrive = m_n * TRAVEL;
    fl = (m_t < arrive) ? m_f + m_dir * (m_t / TRAVEL) : m_d;
    mu = (m_t < arrive) && (m_dir > 0);
    md = (m_t < arrive) && (m_dir < 0);
    dr = (m_t >= arrive) && (m_t < arrive + DOORT);
    c  = (m_t == arrive) ? (3'b001 << m_d) : 3'b000;
    return {1'b0, 2'(fl), 1'b1, mu, md, dr, c};
  endfunction

  // Per-cycle comparison against the model plus safety invariants.
  always @(negedge clk) begin
    if (!rst) begin
      chk("outs", 32'(dut_vec), 32'(exp_vec()));
      chk("motor_excl", 32'(motor_up & motor_down), 32'd0);
      chk("door_motor", 32'(door_open & (motor_up | motor_down)), 32'd0);
      if (cnt_en) clr_cnt += int'(st_clr) + int'(nd_clr) + int'(rd_clr);
    end
  end

  task automatic issue(input logic [1:0] f);
    @(negedge clk);
    req_valid = 1'b1;
    open_when = f;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (!m_busy && req_ready) found = 1;
    end
    if (!found) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    open_when = 2'b00;
    #2;
    chk("reset_state", 32'(dut_vec), 32'(RESET_VEC));
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // ST -> RD, RD -> ST, ST -> ND, ND -> ND
    issue(2'b10); wait_idle(60);
    chk("at_rd", 32'(floor), 32'd2);
    issue(2'b00); wait_idle(60);
    chk("at_st", 32'(floor), 32'd0);
    issue(2'b01); wait_idle(60);
    issue(2'b01); wait_idle(60);
    chk("at_nd", 32'(floor), 32'd1);

    // Competing request while moving up is dropped
    issue(2'b10);
    @(negedge clk);
    req_valid = 1'b1;
    open_when = 2'b00;
    repeat (3) begin
      @(negedge clk);
      chk("busy_not_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    wait_idle(60);
    chk("dest_kept", 32'(floor), 32'd2);

    // Invalid encoding in IDLE changes nothing
    issue(2'b11);
    repeat (3) @(negedge clk);
    chk("invalid_ignored", 32'(is_mooving), 32'd0);

    // Reset during travel from ST towards RD, after passing ND
    issue(2'b00); wait_idle(60);
    issue(2'b10);
    repeat (5) @(negedge clk);
    chk("mid_floor", 32'(floor), 32'd1);
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'(dut_vec), 32'(RESET_VEC));
    @(negedge clk);
    rst = 1'b0;
    issue(2'b01); wait_idle(60);
    chk("after_rst", 32'(floor), 32'd1);

    // Random requests, including invalid and busy-time ones
    cnt_en = 1;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      req_valid = ($urandom_range(0, 3) == 0);
      open_when = 2'($urandom_range(0, 3));
    end
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle(60);
    @(negedge clk);
    cnt_en = 0;
    chk("clr_per_req", 32'(clr_cnt), 32'(acc_cnt));
    chk("some_accepts", 32'(acc_cnt > 5), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
